// File: rtl/instr_mem_fetch_if.sv
// Fetch and byte-load bus of the Y86 instruction memory.
// Fetch handshake: a request is taken on a rising edge when fetch_req_i=1 and the output
// register is free (fetch_valid_o=0 or fetch_ready_i=1). A held result stays stable while
// fetch_valid_o=1 and fetch_ready_i=0.
interface instr_mem_fetch_if #(
   parameter int ADDR_W      = 64,
   parameter int FETCH_BYTES = 10
);
   logic                     fetch_req_i;
   logic [ADDR_W-1:0]        fetch_addr_i;
   logic                     fetch_ready_i;
   logic                     fetch_valid_o;
   logic [8*FETCH_BYTES-1:0] instr_o;
   logic                     imem_error_o;

   logic                     load_start_i;
   logic [ADDR_W-1:0]        load_addr_i;
   logic                     load_valid_i;
   logic [7:0]               load_data_i;
   logic                     load_error_o;

   modport master (
      output fetch_req_i, fetch_addr_i, fetch_ready_i,
      output load_start_i, load_addr_i, load_valid_i, load_data_i,
      input  fetch_valid_o, instr_o, imem_error_o, load_error_o
   );

   modport slave (
      input  fetch_req_i, fetch_addr_i, fetch_ready_i,
      input  load_start_i, load_addr_i, load_valid_i, load_data_i,
      output fetch_valid_o, instr_o, imem_error_o, load_error_o
   );
endinterface

// File: rtl/instr_mem_fetch.sv
// Byte-addressed instruction memory returning a little-endian FETCH_BYTES window with one
// cycle of latency, a one-entry output register, and a streaming byte-load port.
module instr_mem_fetch #(
   parameter int DEPTH       = 1024,
   parameter int FETCH_BYTES = 10,
   parameter int ADDR_W      = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   instr_mem_fetch_if.slave      bus
);
   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   L_FB    = (ADDR_W+1)'(FETCH_BYTES);

   logic [7:0]                   r_mem [0:DEPTH-1];
   logic [ADDR_W-1:0]            r_ptr;
   logic                         r_load_error;
   logic                         r_valid;
   logic [8*FETCH_BYTES-1:0]     r_instr;
   logic                         r_imem_error;

   logic [ADDR_W-1:0]            w_wr_ptr;
   logic                         w_wr_in_range;
   logic                         w_wr_en;
   logic [ADDR_W-1:0]            w_ptr_next;
   logic                         w_accept;
   logic [ADDR_W:0]              w_fetch_end;
   logic                         w_fetch_err;
   logic [8*FETCH_BYTES-1:0]     w_window;

   // A start and a write in the same cycle target load_addr_i directly.
   assign w_wr_ptr      = bus.load_start_i ? bus.load_addr_i : r_ptr;
   assign w_wr_in_range = ({1'b0, w_wr_ptr} < L_DEPTH);
   assign w_wr_en       = bus.load_valid_i && w_wr_in_range;

   always_comb begin
      w_ptr_next = r_ptr;
      if (bus.load_valid_i) begin
         w_ptr_next = (w_wr_ptr == '1) ? w_wr_ptr : w_wr_ptr + 1'b1;
      end else if (bus.load_start_i) begin
         w_ptr_next = bus.load_addr_i;
      end
   end

   // Widened sum so addresses near all-ones cannot wrap into low memory.
   assign w_fetch_end = {1'b0, bus.fetch_addr_i} + L_FB;
   assign w_fetch_err = (w_fetch_end > L_DEPTH);
   assign w_accept    = bus.fetch_req_i && (!r_valid || bus.fetch_ready_i);

   // Each window byte bypasses the array when the same-cycle load write hits it.
   for (genvar g = 0; g < FETCH_BYTES; g++) begin : g_byte
      logic [ADDR_W-1:0] w_baddr;
      logic [7:0]        w_bdata;
      assign w_baddr = bus.fetch_addr_i + ADDR_W'(g);
      assign w_bdata = (w_wr_en && (w_wr_ptr == w_baddr)) ? bus.load_data_i
                                                          : r_mem[w_baddr[IDX_W-1:0]];
      assign w_window[8*g +: 8] = w_bdata;
   end

   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         r_mem[w_wr_ptr[IDX_W-1:0]] <= bus.load_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ptr        <= '0;
         r_load_error <= 1'b0;
      end else begin
         r_ptr <= w_ptr_next;
         if (bus.load_valid_i && !w_wr_in_range) begin
            r_load_error <= 1'b1;
         end else if (bus.load_start_i) begin
            r_load_error <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_valid      <= 1'b0;
         r_instr      <= '0;
         r_imem_error <= 1'b0;
      end else if (w_accept) begin
         r_valid      <= 1'b1;
         r_instr      <= w_fetch_err ? '0 : w_window;
         r_imem_error <= w_fetch_err;
      end else if (r_valid && bus.fetch_ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.fetch_valid_o = r_valid;
   assign bus.instr_o       = r_instr;
   assign bus.imem_error_o  = r_imem_error;
   assign bus.load_error_o  = r_load_error;
endmodule
